imem_dmem_arbiter: RTL and testbench

- Shares one single-port instruction/data memory between the instruction-fetch requester (read-only) and the memory-stage requester (read/write).
- Sequences each access through a request/ready handshake with the memory.
- Generates the per-requester freeze signals that stall the pipeline while an access is pending.
- Sits between the fetch and memory stages and the unified RAM.

---
 rtl/arb_pkg.sv | 16 +
 rtl/arb_starve_ctr.sv | 44 ++++
 rtl/imem_dmem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Holds the FSM state encodings and the default address/data widths.
package arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StIfAcc   = 3'd1,
        StMemAcc  = 3'd2,
        StIfResp  = 3'd3,
        StMemResp = 3'd4
    } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Fetch starvation counter for the memory arbiter.
// Counts MEM grants made while a fetch is waiting; clears on every IF grant and
// saturates at STARVE_LIMIT. force_if tells the arbiter to grant IF next time.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   mem_grant_pend  MEM granted this cycle while if_req was high
//   if_grant        IF granted this cycle
//   force_if        counter has reached STARVE_LIMIT
module arb_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_grant_pend,
    input  logic if_grant,
    output logic force_if
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (if_grant) begin
            cnt_d = '0;
        end else if (mem_grant_pend && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_if = (cnt_q == LIMIT);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-port unified RAM between instruction fetch
// (read-only) and the memory stage (read/write).
// Each access runs IDLE -> *_ACC (ram_req until ram_ready) -> *_RESP (valid
// pulse) -> IDLE. MEM has priority in IDLE; defining ARB_STARVE_GUARD_EN adds
// a counter that forces an IF grant after STARVE_LIMIT MEM grants with a
// fetch pending.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   if_req/if_addr/if_flush        fetch request, address, redirect
//   if_rdata/if_valid/if_freeze    fetch data, completion pulse, stall
//   mem_req/we/addr/wdata          data request
//   mem_rdata/mem_valid/mem_freeze data read value, completion pulse, stall
//   ram_req/we/addr/wdata          RAM access strobe and command
//   ram_rdata/ram_ready            RAM read data and access-complete
module imem_dmem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_freeze,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    output logic              mem_freeze,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready
);

    arb_state_e state_q, state_d;

    logic              lat_we_q;
    logic [ADDR_W-1:0] lat_addr_q;
    logic [DATA_W-1:0] lat_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              discard_q, discard_d;

    logic idle;
    logic if_ok;
    logic mem_grant;
    logic if_grant;
    logic in_acc;

    assign idle  = (state_q == StIdle);
    assign if_ok = if_req & ~if_flush;

`ifdef ARB_STARVE_GUARD_EN
    logic force_if;

    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk           (clk),
        .rst           (rst),
        .mem_grant_pend(mem_grant & if_req),
        .if_grant      (if_grant),
        .force_if      (force_if)
    );

    assign mem_grant = idle & mem_req & ~(force_if & if_ok);
`else
    logic unused_starve_limit;
    assign unused_starve_limit = |STARVE_LIMIT;

    assign mem_grant = idle & mem_req;
`endif

    assign if_grant = idle & if_ok & ~mem_grant;
    assign in_acc   = (state_q == StIfAcc) || (state_q == StMemAcc);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (mem_grant) begin
                    state_d = StMemAcc;
                end else if (if_grant) begin
                    state_d = StIfAcc;
                end
            end
            StIfAcc:   if (ram_ready) state_d = StIfResp;
            StMemAcc:  if (ram_ready) state_d = StMemResp;
            StIfResp:  state_d = StIdle;
            StMemResp: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs. A flush arriving in IF_RESP itself suppresses the pulse directly.
    always_comb begin
        ram_req   = in_acc;
        ram_we    = (state_q == StMemAcc) & lat_we_q;
        ram_addr  = in_acc ? lat_addr_q : '0;
        ram_wdata = in_acc ? lat_wdata_q : '0;
        if_valid  = (state_q == StIfResp) & ~discard_q & ~if_flush;
        mem_valid = (state_q == StMemResp);
    end

    assign if_freeze  = if_req & ~if_valid;
    assign mem_freeze = mem_req & ~mem_valid;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;

    // Discard flag: set by a flush during the fetch, cleared on leaving IF_RESP.
    always_comb begin
        discard_d = discard_q;
        if (state_q == StIfResp) begin
            discard_d = 1'b0;
        end else if ((state_q == StIfAcc) && if_flush) begin
            discard_d = 1'b1;
        end
    end

    // Request latch and read-data capture. IF grants latch a zero write command
    // so ram_we/ram_wdata stay 0 during fetches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            discard_q   <= 1'b0;
        end else begin
            discard_q <= discard_d;
            if (mem_grant) begin
                lat_we_q    <= mem_we;
                lat_addr_q  <= mem_addr;
                lat_wdata_q <= mem_wdata;
            end else if (if_grant) begin
                lat_we_q    <= 1'b0;
                lat_addr_q  <= if_addr;
                lat_wdata_q <= '0;
            end
            if ((state_q == StIfAcc) && ram_ready && !discard_q && !if_flush) begin
                if_rdata_q <= ram_rdata;
            end
            if ((state_q == StMemAcc) && ram_ready && !lat_we_q) begin
                mem_rdata_q <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter. Inputs change 1 ns after the rising
// edge; outputs are checked on the falling edge. Build with
// +define+ARB_STARVE_GUARD_EN to exercise the starvation guard (STARVE_LIMIT=2).
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush;
    logic [31:0] if_addr, if_rdata;
    logic        if_valid, if_freeze;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_valid, mem_freeze;
    logic        ram_req, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_ready;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    int unsigned if_grants  = 0;
    int unsigned mem_grants = 0;

    always #5 clk = ~clk;

    imem_dmem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_LIMIT(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_freeze (if_freeze),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .mem_freeze(mem_freeze),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ready (ram_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the drive point of the next cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance to the check point of the current cycle.
    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        if_req = 0; if_flush = 0; if_addr = 0;
        mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
        ram_rdata = 0; ram_ready = 0;
        #2;
        chk("rst_ram_req", ram_req, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_valids", {if_valid, mem_valid}, 0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();

        // 1: fetch with no wait state
        if_req = 1; if_addr = 32'h10;
        mid(); chk("t1_c0_if_freeze", if_freeze, 1); chk("t1_c0_ram_req", ram_req, 0);
        cyc(); ram_ready = 1; ram_rdata = 32'hE3A00001;
        mid(); chk("t1_c1_ram_req", ram_req, 1); chk("t1_c1_ram_addr", ram_addr, 32'h10);
        chk("t1_c1_ram_we", ram_we, 0); chk("t1_c1_if_freeze", if_freeze, 1);
        cyc(); ram_ready = 0;
        mid(); chk("t1_c2_if_valid", if_valid, 1); chk("t1_c2_if_rdata", if_rdata, 32'hE3A00001);
        chk("t1_c2_if_freeze", if_freeze, 0);
        cyc(); if_req = 0;
        mid(); chk("t1_c3_idle", {ram_req, if_valid}, 0);

        // 2: simultaneous MEM write and IF fetch
        cyc();
        mem_req = 1; mem_we = 1; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF;
        if_req = 1; if_addr = 32'h14;
        mid(); chk("t2_c0_freezes", {if_freeze, mem_freeze}, 2'b11);
        cyc(); ram_ready = 1; ram_rdata = 32'h0BADF00D;
        mid(); chk("t2_c1_ram_we", ram_we, 1); chk("t2_c1_ram_addr", ram_addr, 32'h100);
        chk("t2_c1_ram_wdata", ram_wdata, 32'hDEADBEEF); chk("t2_c1_if_freeze", if_freeze, 1);
        cyc(); ram_ready = 0;
        mid(); chk("t2_c2_mem_valid", mem_valid, 1); chk("t2_c2_mem_freeze", mem_freeze, 0);
        chk("t2_c2_mem_rdata", mem_rdata, 0); chk("t2_c2_if_freeze", if_freeze, 1);
        cyc(); mem_req = 0; mem_we = 0;
        mid(); chk("t2_c3_ram_req", ram_req, 0); chk("t2_c3_if_freeze", if_freeze, 1);
        cyc(); ram_ready = 1; ram_rdata = 32'hAABBCCDD;
        mid(); chk("t2_c4_ram_addr", ram_addr, 32'h14); chk("t2_c4_ram_we", ram_we, 0);
        chk("t2_c4_ram_wdata", ram_wdata, 0); chk("t2_c4_if_freeze", if_freeze, 1);
        cyc(); ram_ready = 0;
        mid(); chk("t2_c5_if_valid", if_valid, 1); chk("t2_c5_if_rdata", if_rdata, 32'hAABBCCDD);
        chk("t2_c5_if_freeze", if_freeze, 0);
        cyc(); if_req = 0;
        mid(); chk("t2_c6_idle", ram_req, 0);

        // 3: MEM read with three wait states
        cyc(); mem_req = 1; mem_we = 0; mem_addr = 32'h200; mem_wdata = 32'h55;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            mid();
            chk("t3_wait_cmd", {ram_req, ram_we, ram_addr}, {2'b10, 32'h200});
            chk("t3_wait_mem_valid", mem_valid, 0);
        end
        cyc(); ram_ready = 1; ram_rdata = 32'h12345678;
        mid(); chk("t3_c4_cmd", {ram_req, ram_we, ram_addr}, {2'b10, 32'h200});
        cyc(); ram_ready = 0;
        mid(); chk("t3_c5_mem_valid", mem_valid, 1); chk("t3_c5_mem_rdata", mem_rdata, 32'h12345678);
        cyc(); mem_req = 0;
        mid(); chk("t3_c6_mem_valid", mem_valid, 0);

        // 4: flush during the fetch
        cyc(); if_req = 1; if_addr = 32'h20;
        cyc(); if_flush = 1;
        mid(); chk("t4_c1_ram_req", ram_req, 1);
        cyc(); if_flush = 0; if_addr = 32'h40; ram_ready = 1; ram_rdata = 32'h99999999;
        cyc(); ram_ready = 0;
        mid(); chk("t4_c3_if_valid", if_valid, 0); chk("t4_c3_if_rdata", if_rdata, 32'hAABBCCDD);
        chk("t4_c3_if_freeze", if_freeze, 1);
        cyc();
        mid(); chk("t4_c4_idle", ram_req, 0); chk("t4_c4_if_valid", if_valid, 0);
        cyc(); ram_ready = 1; ram_rdata = 32'h0A0A0A0A;
        mid(); chk("t4_c5_ram_req", ram_req, 1); chk("t4_c5_ram_addr", ram_addr, 32'h40);
        cyc(); ram_ready = 0;
        mid(); chk("t4_c6_if_valid", if_valid, 1); chk("t4_c6_if_rdata", if_rdata, 32'h0A0A0A0A);
        cyc(); if_req = 0;

        // 5: reset during a MEM access
        cyc(); mem_req = 1; mem_we = 0; mem_addr = 32'h300;
        cyc();
        mid(); chk("t5_c1_ram_req", ram_req, 1);
        cyc(); mem_req = 0; rst = 0;
        #1;
        chk("t5_rst_ram", {ram_req, ram_we, ram_addr, ram_wdata}, 0);
        chk("t5_rst_rdata", {if_rdata, mem_rdata}, 0);
        chk("t5_rst_valid_freeze", {if_valid, mem_valid, if_freeze, mem_freeze}, 0);
        cyc(); rst = 1;
        for (int i = 0; i < 3; i++) begin
            mid(); chk("t5_post_no_valid", {mem_valid, ram_req}, 0);
            cyc();
        end
        mem_req = 1; mem_addr = 32'h304;
        cyc(); ram_ready = 1; ram_rdata = 32'hCAFE0304;
        mid(); chk("t5_new_ram_addr", ram_addr, 32'h304);
        cyc(); ram_ready = 0;
        mid(); chk("t5_new_mem_valid", mem_valid, 1); chk("t5_new_mem_rdata", mem_rdata, 32'hCAFE0304);
        cyc(); mem_req = 0;

        // 6: both requests held, RAM always ready
        cyc();
        mem_req = 1; mem_we = 1; mem_addr = 32'h500; mem_wdata = 32'h1;
        if_req = 1; if_addr = 32'h600; ram_ready = 1; ram_rdata = 32'h77;
        for (int i = 0; i < 18; i++) begin
            mid();
            if (ram_req && ram_addr == 32'h600) if_grants++;
            if (ram_req && ram_addr == 32'h500) mem_grants++;
            cyc();
        end
        mem_req = 0; if_req = 0; ram_ready = 0;
`ifdef ARB_STARVE_GUARD_EN
        chk("t6_if_grants", if_grants, 2);
        chk("t6_mem_grants", mem_grants, 4);
`else
        chk("t6_if_grants", if_grants, 0);
        chk("t6_mem_grants", mem_grants, 6);
`endif
        mid(); chk("t6_idle", ram_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
